imem_boot_loader: RTL and testbench

- Loads a program image from a byte stream (UART receiver side) into the CPU's single-port instruction memory, then releases the CPU.
- Owns the instruction memory address/write port. While loading, it drives the port and stalls the pipeline. When idle, it passes the CPU fetch address straight through with writes disabled.
- Sits between the byte receiver, the IF stage and the instruction memory.

---
 rtl/cpu_defs.sv | 16 +
 rtl/word_assembler.sv | 33 +++
 rtl/imem_boot_loader.sv | 133 +++++++++++++
 tb/tb_imem_boot_loader.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared loader definitions: FSM state encoding and the bytes-per-word constant.
package cpu_defs;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        FINISH = 3'd5,
        ERR    = 3'd6
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs little-endian bytes into a 32-bit word; word_full flags the byte completing it (same cycle).
// No backpressure of its own: it shifts whenever i_shift_en is high.
module word_assembler
    import cpu_defs::*;
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_clear,
    input  logic                          i_shift_en,
    input  logic [7:0]                    i_byte,
    output logic [8*BYTES_PER_WORD-1:0]   o_word,
    output logic                          o_word_full
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [IDX_W-1:0]              r_idx;
    logic [8*BYTES_PER_WORD-1:0]   r_word;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_shift_en) begin
            r_word[{r_idx, 3'b000} +: 8] <= i_byte;
            r_idx                        <= r_idx + 1'b1;
        end
    end

    assign o_word      = r_word;
    assign o_word_full = i_shift_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory, stalling the CPU until done.
// Word write lands one cycle after its last byte; rx_ready drops during WRITE/FINISH/ERR.
module imem_boot_loader
    import cpu_defs::*;
#(
    parameter int RAM_SIZE     = 256,
    parameter int RAM_SIZE_BIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    input  logic [RAM_SIZE_BIT-1:0] cpu_addr,
    output logic [RAM_SIZE_BIT-1:0] mem_address,
    output logic                    mem_write,
    output logic [31:0]             mem_write_data,
    output logic                    cpu_stall,
    output logic                    load_done,
    output logic                    load_err
);

    localparam logic [15:0] MAX_LEN = 16'(RAM_SIZE);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_len_lo;
    logic [15:0]             r_len;
    // One bit wider than the address so N == RAM_SIZE compares without wrapping.
    logic [RAM_SIZE_BIT:0]   r_word_cnt;
    logic                    r_load_err;

    logic [15:0]             w_len;
    logic [RAM_SIZE_BIT:0]   w_cnt_inc;
    logic                    w_last;
    logic                    w_start_ok;
    logic                    w_shift_en;
    logic                    w_word_full;
    logic [31:0]             w_word;

    assign w_len      = {rx_data, r_len_lo};
    assign w_cnt_inc  = r_word_cnt + 1'b1;
    assign w_last     = (16'(w_cnt_inc) == r_len);
    assign w_start_ok = start && (r_state == IDLE || r_state == ERR);
    assign w_shift_en = (r_state == DATA) && rx_valid;

    word_assembler u_word_asm (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_start_ok),
        .i_shift_en  (w_shift_en),
        .i_byte      (rx_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_word_cnt <= '0;
                r_load_err <= 1'b0;
            end
            if (r_state == LEN_LO && rx_valid) begin
                r_len_lo <= rx_data;
            end
            if (r_state == LEN_HI && rx_valid) begin
                r_len <= w_len;
                if (w_len > MAX_LEN) begin
                    r_load_err <= 1'b1;
                end
            end
            if (r_state == WRITE) begin
                r_word_cnt <= w_cnt_inc;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        rx_ready     = 1'b0;
        mem_write    = 1'b0;
        load_done    = 1'b0;
        cpu_stall    = 1'b1;
        mem_address  = r_word_cnt[RAM_SIZE_BIT-1:0];
        case (r_state)
            IDLE: begin
                cpu_stall   = 1'b0;
                mem_address = cpu_addr;
                if (start) w_next_state = LEN_LO;
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) w_next_state = LEN_HI;
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (w_len == '0)         w_next_state = FINISH;
                    else if (w_len > MAX_LEN) w_next_state = ERR;
                    else                      w_next_state = DATA;
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (w_word_full) w_next_state = WRITE;
            end
            WRITE: begin
                mem_write    = 1'b1;
                w_next_state = w_last ? FINISH : DATA;
            end
            FINISH: begin
                load_done    = 1'b1;
                w_next_state = IDLE;
            end
            ERR: begin
                if (start) w_next_state = LEN_LO;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign mem_write_data = w_word;
    assign load_err       = r_load_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench: a write scoreboard built from the byte images sent, per-cycle rule checks and literal expectations.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  cpu_addr;
    logic [7:0]  mem_address;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic        cpu_stall;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    imem_boot_loader #(.RAM_SIZE(256), .RAM_SIZE_BIT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .cpu_addr       (cpu_addr),
        .mem_address    (mem_address),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .cpu_stall      (cpu_stall),
        .load_done      (load_done),
        .load_err       (load_err)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] dut_mem [256];
    logic [31:0] exp_mem [256];
    int          n_checks  = 0;
    int          n_err     = 0;
    int          n_writes  = 0;
    int          got_done  = 0;
    int          exp_done  = 0;
    logic [7:0]  last_addr = 8'h00;
    bit          mon_en    = 1'b0;

    // The instruction memory the loader is filling.
    always @(posedge clk) begin
        if (mem_write) dut_mem[mem_address] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the scoreboard and the idle/stall rules.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!cpu_stall) begin
                chk("idle_passthru_addr", {24'h0, mem_address}, {24'h0, cpu_addr});
                chk("idle_no_write", {31'h0, mem_write}, 32'h0);
                chk("idle_not_ready", {31'h0, rx_ready}, 32'h0);
            end
            if (rx_ready) chk("ready_no_write", {31'h0, mem_write}, 32'h0);
            if (load_done) begin
                got_done++;
                chk("done_while_stalled", {31'h0, cpu_stall}, 32'h1);
                chk("done_no_write", {31'h0, mem_write}, 32'h0);
            end
            if (mem_write) begin
                n_writes++;
                last_addr = mem_address;
                if (exp_q.size() == 0) begin
                    chk("spurious_write_addr", {24'h0, mem_address}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {24'h0, mem_address}, {24'h0, e.a});
                    chk("write_data", mem_write_data, e.d);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        sync();
        start = 1'b0;
    endtask

    // Offer one byte after `gap` idle cycles; returns just after the edge that took it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int n;
        rx_valid = 1'b0;
        repeat (gap) sync();
        rx_valid = 1'b1;
        rx_data  = b;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            at_neg();
            ok = rx_ready;
            sync();
            n++;
        end
        if (!ok) chk("rx_accept_timeout", 32'h0, 32'h1);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gmax);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], $urandom_range(0, gmax));
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
        exp_mem[a] = d;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            at_neg();
            n++;
        end while (cpu_stall && n < 3000);
        chk("idle_timeout", {31'h0, cpu_stall}, 32'h0);
        sync();
    endtask

    initial begin
        int          w0;
        logic [31:0] w;
        logic [31:0] old3;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        cpu_addr = 8'h3C;

        // Reset values
        @(posedge clk);
        at_neg();
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_done", {31'h0, load_done}, 32'h0);
        chk("rst_err", {31'h0, load_err}, 32'h0);
        chk("rst_addr", {24'h0, mem_address}, 32'h3C);
        sync();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Nominal two-word load, with an ignored start mid-load
        at_neg();
        chk("nom_stall_before", {31'h0, cpu_stall}, 32'h0);
        sync();
        expect_write(8'd0, 32'h1234_5678);
        expect_write(8'd1, 32'hDEAD_BEEF);
        exp_done++;
        do_start();
        at_neg();
        chk("nom_stall_after_start", {31'h0, cpu_stall}, 32'h1);
        chk("nom_ready_len_lo", {31'h0, rx_ready}, 32'h1);
        sync();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        do_start();
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        send_byte(8'h12, 0);
        at_neg();
        chk("nom_w0_write", {31'h0, mem_write}, 32'h1);
        chk("nom_w0_addr", {24'h0, mem_address}, 32'h0);
        chk("nom_w0_data", mem_write_data, 32'h1234_5678);
        chk("nom_w0_not_ready", {31'h0, rx_ready}, 32'h0);
        sync();
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
        at_neg();
        chk("nom_w1_addr", {24'h0, mem_address}, 32'h1);
        chk("nom_w1_data", mem_write_data, 32'hDEAD_BEEF);
        sync();
        at_neg();
        chk("nom_done_pulse", {31'h0, load_done}, 32'h1);
        chk("nom_finish_stall", {31'h0, cpu_stall}, 32'h1);
        sync();
        at_neg();
        chk("nom_done_cleared", {31'h0, load_done}, 32'h0);
        chk("nom_stall_released", {31'h0, cpu_stall}, 32'h0);
        sync();
        chk("nom_mem0", dut_mem[0], 32'h1234_5678);
        chk("nom_mem1", dut_mem[1], 32'hDEAD_BEEF);
        chk("nom_done_count", got_done, 1);

        // Zero-length image
        w0 = n_writes;
        exp_done++;
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        at_neg();
        chk("zero_done_pulse", {31'h0, load_done}, 32'h1);
        sync();
        at_neg();
        chk("zero_stall_released", {31'h0, cpu_stall}, 32'h0);
        sync();
        chk("zero_no_writes", n_writes, w0);
        chk("zero_done_count", got_done, exp_done);

        // Oversize header (N=257), error hold, then recovery
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("err_flag", {31'h0, load_err}, 32'h1);
            chk("err_not_ready", {31'h0, rx_ready}, 32'h0);
            chk("err_stall", {31'h0, cpu_stall}, 32'h1);
            sync();
        end
        rx_valid = 1'b0;
        do_start();
        at_neg();
        chk("err_cleared_by_start", {31'h0, load_err}, 32'h0);
        chk("err_restart_ready", {31'h0, rx_ready}, 32'h1);
        sync();
        expect_write(8'd0, 32'hCAFE_F00D);
        exp_done++;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hCAFE_F00D, 0);
        wait_idle();
        chk("err_recover_mem0", dut_mem[0], 32'hCAFE_F00D);

        // Full-size image with random gaps on rx_valid
        w0 = n_writes;
        exp_done++;
        do_start();
        send_byte(8'h00, 1);
        send_byte(8'h01, 2);
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            expect_write(8'(i), w);
            send_word(w, 2);
        end
        wait_idle();
        chk("full_write_count", n_writes - w0, 256);
        chk("full_last_addr", {24'h0, last_addr}, 32'hFF);
        chk("full_queue_drained", exp_q.size(), 0);
        chk("full_mem0", dut_mem[0], exp_mem[0]);
        chk("full_mem255", dut_mem[255], exp_mem[255]);
        chk("full_done_count", got_done, exp_done);

        // Reset after byte 2 of word 3
        old3 = exp_mem[3];
        do_start();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            expect_write(8'(i), w);
            send_word(w, 1);
        end
        w = $urandom;
        send_byte(w[7:0], 0);
        send_byte(w[15:8], 0);
        chk("rst_mid_queue", exp_q.size(), 0);
        reset = 1'b1;
        sync();
        reset    = 1'b0;
        cpu_addr = 8'h77;
        at_neg();
        chk("rst_mid_stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_mid_addr", {24'h0, mem_address}, 32'h77);
        chk("rst_mid_write", {31'h0, mem_write}, 32'h0);
        sync();
        repeat (3) sync();
        for (int i = 0; i < 3; i++) chk("rst_mid_kept", dut_mem[i], exp_mem[i]);
        chk("rst_mid_word3_untouched", dut_mem[3], old3);

        // Idle pass-through sweep with a byte on offer
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        for (int i = 0; i < 256; i++) begin
            cpu_addr = 8'(i);
            at_neg();
            chk("sweep_addr", {24'h0, mem_address}, i);
            chk("sweep_not_ready", {31'h0, rx_ready}, 32'h0);
            sync();
        end
        rx_valid = 1'b0;

        chk("final_done_count", got_done, exp_done);
        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
